// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared definitions for the multiplier arbiter slice
package mul_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_ACCEPT,
        ST_RUN,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/mul_arbiter_if.sv
// rtl/mul_arbiter_if.sv - requester and multiplier signals around the arbiter
interface mul_arbiter_if #(parameter int N = mul_pkg::N_DEFAULT);

    logic           req0;
    logic           req1;
    logic           signed0;
    logic           signed1;
    logic [N-1:0]   a0;
    logic [N-1:0]   b0;
    logic [N-1:0]   a1;
    logic [N-1:0]   b1;
    logic           ack0;
    logic           ack1;
    logic [2*N-1:0] result;
    logic           busy;
    logic           mul_start;
    logic           mul_signed;
    logic [N-1:0]   mul_word1;
    logic [N-1:0]   mul_word2;
    logic [2*N-1:0] mul_product;
    logic           mul_ready;

    // Arbiter side
    modport slave (
        input  req0, req1, signed0, signed1, a0, b0, a1, b1, mul_product, mul_ready,
        output ack0, ack1, result, busy, mul_start, mul_signed, mul_word1, mul_word2
    );

    // Requesters plus multiplier side
    modport master (
        output req0, req1, signed0, signed1, a0, b0, a1, b1, mul_product, mul_ready,
        input  ack0, ack1, result, busy, mul_start, mul_signed, mul_word1, mul_word2
    );

endinterface

// File: rtl/mul.sv
// rtl/mul.sv - fixed-latency shared multiplier with start/ready handshake
module mul #(parameter int N = mul_pkg::N_DEFAULT) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   word1,
    input  logic [N-1:0]   word2,
    output logic [2*N-1:0] product,
    output logic           ready
);

    logic [2*N-1:0] product_q, product_d;
    logic           ready_q, ready_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [2*N-1:0] ext1, ext2;

    // Low 2N bits of the extended product are correct for both signednesses.
    always_comb begin
        ext1 = is_signed ? {{N{word1[N-1]}}, word1} : {{N{1'b0}}, word1};
        ext2 = is_signed ? {{N{word2[N-1]}}, word2} : {{N{1'b0}}, word2};
        product_d = product_q;
        ready_d   = ready_q;
        cnt_d     = cnt_q;
        if (start) begin
            product_d = ext1 * ext2;
            ready_d   = 1'b0;
            cnt_d     = 2'd3;
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product_q <= '0;
            ready_q   <= 1'b1;
            cnt_q     <= 2'd0;
        end else begin
            product_q <= product_d;
            ready_q   <= ready_d;
            cnt_q     <= cnt_d;
        end
    end

    assign product = product_q;
    assign ready   = ready_q;

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant decision
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Under contention the requester not served last wins.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin arbiter sharing one multiplier between two requesters
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    mul_arbiter_if.slave bus
);

    arb_state_e     state_q, state_d;
    logic [1:0]     grant_q, grant_d;
    logic           last_q, last_d;
    logic           start_q, start_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           busy_q, busy_d;
    logic           signed_q, signed_d;
    logic [N-1:0]   word1_q, word1_d;
    logic [N-1:0]   word2_q, word2_d;
    logic [2*N-1:0] result_q, result_d;
    logic [1:0]     rr_grant;

    rr_arb2 u_rr_arb2 (
        .req   ({bus.req1, bus.req0}),
        .last  (last_q),
        .grant (rr_grant)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        start_d  = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        signed_d = signed_q;
        word1_d  = word1_q;
        word2_d  = word2_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_grant != 2'b00) begin
                    grant_d = rr_grant;
                    if (rr_grant[1]) begin
                        word1_d  = bus.a1;
                        word2_d  = bus.b1;
                        signed_d = bus.signed1;
                    end else begin
                        word1_d  = bus.a0;
                        word2_d  = bus.b0;
                        signed_d = bus.signed0;
                    end
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_d = ST_ACCEPT;
            ST_ACCEPT: begin
                if (!bus.mul_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Ack is registered here so it is high exactly while in DONE.
                if (bus.mul_ready) begin
                    result_d = bus.mul_product;
                    ack0_d   = grant_q[0];
                    ack1_d   = grant_q[1];
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = grant_q[1];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            start_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            busy_q   <= 1'b0;
            signed_q <= 1'b0;
            word1_q  <= '0;
            word2_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            start_q  <= start_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= busy_d;
            signed_q <= signed_d;
            word1_q  <= word1_d;
            word2_q  <= word2_d;
            result_q <= result_d;
        end
    end

    assign bus.mul_start  = start_q;
    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.busy       = busy_q;
    assign bus.mul_signed = signed_q;
    assign bus.mul_word1  = word1_q;
    assign bus.mul_word2  = word2_q;
    assign bus.result     = result_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb/tb_mul_arbiter.sv - directed scoreboard bench for mul_arbiter with the shared multiplier
module tb_mul_arbiter;

    localparam int N = 4;

    typedef struct packed {
        logic       id;
        logic [7:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   starts;
    exp_t sb[$];

    always #5 clk = ~clk;

    mul_arbiter_if #(.N(N)) bus();

    mul_arbiter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mul #(.N(N)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start     (bus.mul_start),
        .is_signed (bus.mul_signed),
        .word1     (bus.mul_word1),
        .word2     (bus.mul_word2),
        .product   (bus.mul_product),
        .ready     (bus.mul_ready)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [7:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input string tag, output int n_start);
        exp_t e;
        bit   seen;
        seen    = 0;
        n_start = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (bus.mul_start) n_start++;
            if (bus.ack0 || bus.ack1) begin
                seen = 1;
                if (sb.size() == 0) begin
                    check({tag, "_unexpected_ack"}, 16'd1, 16'd0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_ack_excl"}, {15'd0, bus.ack0 & bus.ack1}, 16'd0);
                    check({tag, "_ack_id"}, {15'd0, bus.ack1}, {15'd0, e.id});
                    check({tag, "_result"}, {8'd0, bus.result}, {8'd0, e.res});
                end
            end
        end
        if (!seen) check({tag, "_ack_timeout"}, 16'd0, 16'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   {15'd0, bus.busy},       16'd0);
        check({tag, "_start"},  {15'd0, bus.mul_start},  16'd0);
        check({tag, "_ack0"},   {15'd0, bus.ack0},       16'd0);
        check({tag, "_ack1"},   {15'd0, bus.ack1},       16'd0);
        check({tag, "_signed"}, {15'd0, bus.mul_signed}, 16'd0);
        check({tag, "_word1"},  {12'd0, bus.mul_word1},  16'd0);
        check({tag, "_word2"},  {12'd0, bus.mul_word2},  16'd0);
        check({tag, "_result"}, {8'd0, bus.result},      16'd0);
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.signed0 = 0; bus.signed1 = 0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        check_idle_outputs("reset");

        // Single unsigned request from requester 0.
        bus.a0 = 4'd3; bus.b0 = 4'd5; bus.signed0 = 0; bus.req0 = 1;
        push(1'b0, 8'h0F);
        @(negedge clk);
        check("t1_start_latency", {15'd0, bus.mul_start}, 16'd1);
        check("t1_busy", {15'd0, bus.busy}, 16'd1);
        wait_ack("t1", starts);
        bus.req0 = 0;
        check("t1_start_count", starts[15:0] + 16'd1, 16'd1);
        @(negedge clk);
        check("t1_word1_hold", {12'd0, bus.mul_word1}, 16'd3);
        check("t1_busy_after", {15'd0, bus.busy}, 16'd0);

        // Signed request from requester 1: -3 * 2.
        bus.a1 = 4'b1101; bus.b1 = 4'b0010; bus.signed1 = 1; bus.req1 = 1;
        push(1'b1, 8'hFA);
        wait_ack("t2", starts);
        bus.req1 = 0; bus.signed1 = 0;
        @(negedge clk);

        // Both requesters held from reset: strict alternation starting at 0.
        bus.a0 = 4'd2; bus.b0 = 4'd3; bus.a1 = 4'd4; bus.b1 = 4'd5;
        bus.req0 = 1; bus.req1 = 1;
        do_reset();
        push(1'b0, 8'h06); push(1'b1, 8'h14); push(1'b0, 8'h06); push(1'b1, 8'h14);
        for (int k = 0; k < 4; k++) wait_ack("t3", starts);
        bus.req0 = 0; bus.req1 = 0;
        repeat (2) @(negedge clk);
        check("t3_busy_after", {15'd0, bus.busy}, 16'd0);

        // Operand change after grant must be ignored.
        bus.a0 = 4'd2; bus.b0 = 4'd2; bus.req0 = 1;
        push(1'b0, 8'h04);
        @(negedge clk);
        bus.a0 = 4'hF;
        check("t4_word1_latched", {12'd0, bus.mul_word1}, 16'd2);
        wait_ack("t4", starts);
        bus.req0 = 0;
        @(negedge clk);

        // Reset while the multiplier is running abandons the operation.
        bus.a0 = 4'd3; bus.b0 = 4'd3; bus.req0 = 1;
        repeat (3) @(negedge clk);
        check("t5_busy_in_run", {15'd0, bus.busy}, 16'd1);
        reset = 1'b1; bus.req0 = 0;
        @(negedge clk);
        check_idle_outputs("t5_reset");
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t5_no_ack", {14'd0, bus.ack1, bus.ack0}, 16'd0);
        end
        bus.req0 = 1;
        push(1'b0, 8'h09);
        wait_ack("t5_after", starts);
        bus.req0 = 0;
        @(negedge clk);
        check("sb_empty", sb.size(), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
